// File: rtl/dds_phase_controller_if.sv
// Control, tuning-word handshake and LUT-side signals of the DDS phase controller.
// DDS_FREQ_SWEEP_EN adds the sweep step/limit inputs.
interface dds_phase_controller_if #(
    parameter int FW_W    = 16,
    parameter int PHASE_W = 10,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic               fw_valid;
    logic [FW_W-1:0]    fw_data;
    logic               fw_ready;
    logic [BURST_W-1:0] burst_len;
    logic [PHASE_W-1:0] counter;
    logic               lut_reset;
    logic               busy;
    logic               period_tick;
    logic               done;
`ifdef DDS_FREQ_SWEEP_EN
    logic [FW_W-1:0]    fw_step;
    logic [FW_W-1:0]    fw_limit;

    modport master (
        output start, stop, fw_valid, fw_data, burst_len, fw_step, fw_limit,
        input  fw_ready, counter, lut_reset, busy, period_tick, done
    );
    modport slave (
        input  start, stop, fw_valid, fw_data, burst_len, fw_step, fw_limit,
        output fw_ready, counter, lut_reset, busy, period_tick, done
    );
`else
    modport master (
        output start, stop, fw_valid, fw_data, burst_len,
        input  fw_ready, counter, lut_reset, busy, period_tick, done
    );
    modport slave (
        input  start, stop, fw_valid, fw_data, burst_len,
        output fw_ready, counter, lut_reset, busy, period_tick, done
    );
`endif
endinterface

// File: rtl/dds_phase_controller.sv
// DDS phase accumulator and sequencer for the sine LUT: start/stop, bursts, phase-continuous retuning.
// Define DDS_FREQ_SWEEP_EN to add a saturating per-period frequency sweep.
module dds_phase_controller #(
    parameter int ACC_W   = 16,
    parameter int PHASE_W = 10,
    parameter int FW_W    = 16,
    parameter int BURST_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dds_phase_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam logic [BURST_W-1:0] ONE = 1;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [FW_W-1:0]    fw_active, fw_active_n;
    logic [FW_W-1:0]    shadow, shadow_n;
    logic               pending, pending_n;
    logic [BURST_W-1:0] burst_cnt, burst_cnt_n;
    logic [BURST_W-1:0] burst_len_q, burst_len_n;
    logic               lut_reset_q, fw_ready_q, busy_q, tick_q, done_q;
    logic [ACC_W:0]     fw_ext, sum;
    logic               wrap, xfer, last_period;

`ifdef DDS_FREQ_SWEEP_EN
    function automatic logic [FW_W-1:0] sat_add(input logic [FW_W-1:0] a,
                                                 input logic [FW_W-1:0] b,
                                                 input logic [FW_W-1:0] lim);
        logic [FW_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[FW_W-1:0];
    endfunction
`endif

    // The carry out of the accumulator add marks the period boundary.
    assign fw_ext      = {{(ACC_W + 1 - FW_W){1'b0}}, fw_active};
    assign sum         = {1'b0, acc} + fw_ext;
    assign wrap        = (state != IDLE) && sum[ACC_W];
    assign xfer        = bus.fw_valid && fw_ready_q;
    assign last_period = (burst_len_q != '0) && ((burst_cnt + ONE) == burst_len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        fw_active_n = fw_active;
        shadow_n    = shadow;
        pending_n   = pending;
        burst_cnt_n = burst_cnt;
        burst_len_n = burst_len_q;

        case (state)
            IDLE:     if (bus.start && !bus.stop) state_n = RUN;
            RUN:      if (wrap && last_period)    state_n = IDLE;
                      else if (bus.stop)          state_n = STOPPING;
            STOPPING: if (wrap || fw_active == '0) state_n = IDLE;
            default:  state_n = IDLE;
        endcase

        if (state == IDLE) begin
            if (xfer) fw_active_n = bus.fw_data;
            if (state_n == RUN) begin
                acc_n       = '0;
                burst_len_n = bus.burst_len;
                burst_cnt_n = '0;
            end
        end else begin
            acc_n = sum[ACC_W-1:0];
            if (wrap) begin
                burst_cnt_n = burst_cnt + ONE;
                if (pending) begin
                    fw_active_n = shadow;
                    pending_n   = 1'b0;
                end
`ifdef DDS_FREQ_SWEEP_EN
                else if (state == RUN) begin
                    fw_active_n = sat_add(fw_active, bus.fw_step, bus.fw_limit);
                end
`endif
            end
            // Retunes while running wait in the shadow so the phase never jumps mid-period.
            if (xfer) begin
                shadow_n  = bus.fw_data;
                pending_n = 1'b1;
            end
            if (state_n == IDLE) begin
                acc_n = '0;
                if (pending_n) begin
                    fw_active_n = shadow_n;
                    pending_n   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            fw_active   <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            burst_cnt   <= '0;
            burst_len_q <= '0;
            lut_reset_q <= 1'b1;
            fw_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc         <= acc_n;
            fw_active   <= fw_active_n;
            shadow      <= shadow_n;
            pending     <= pending_n;
            burst_cnt   <= burst_cnt_n;
            burst_len_q <= burst_len_n;
            lut_reset_q <= (state_n == IDLE);
            fw_ready_q  <= (state_n == IDLE) || !pending_n;
            busy_q      <= (state_n != IDLE);
            tick_q      <= wrap;
            done_q      <= (state != IDLE) && (state_n == IDLE);
        end
    end

    assign bus.counter     = acc[ACC_W-1 -: PHASE_W];
    assign bus.lut_reset   = lut_reset_q;
    assign bus.fw_ready    = fw_ready_q;
    assign bus.busy        = busy_q;
    assign bus.period_tick = tick_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_dds_phase_controller.sv
// Self-checking bench for dds_phase_controller: directed scenarios plus randomized traffic
// checked cycle by cycle against an arithmetic reference model.
module tb_dds_phase_controller;
    localparam int ACC_W   = 16;
    localparam int PHASE_W = 10;
    localparam int FW_W    = 16;
    localparam int BURST_W = 8;
    localparam int VW      = PHASE_W + 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dds_phase_controller_if #(.FW_W(FW_W), .PHASE_W(PHASE_W), .BURST_W(BURST_W)) bus ();

    dds_phase_controller #(
        .ACC_W(ACC_W), .PHASE_W(PHASE_W), .FW_W(FW_W), .BURST_W(BURST_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase as a plain integer, generator either idle or running.
    bit m_active, m_stop_req, m_pend, m_tick, m_done;
    int m_phase, m_fw, m_shadow, m_blen, m_periods;

    task automatic model_reset();
        m_active = 0; m_stop_req = 0; m_pend = 0; m_tick = 0; m_done = 0;
        m_phase = 0; m_fw = 0; m_shadow = 0; m_blen = 0; m_periods = 0;
    endtask

    task automatic model_step();
        bit ready, xfer, finish, w;
        int nxt;
        ready  = !m_active || !m_pend;
        xfer   = bus.fw_valid && ready;
        m_tick = 0; m_done = 0; finish = 0;
        if (!m_active) begin
            if (xfer) m_fw = int'(bus.fw_data);
            if (bus.start && !bus.stop) begin
                m_active = 1; m_stop_req = 0; m_phase = 0;
                m_blen = int'(bus.burst_len); m_periods = 0;
            end
        end else begin
            nxt = m_phase + m_fw;
            w   = (nxt >= 2 ** ACC_W);
            if (m_stop_req) finish = w || (m_fw == 0);
            else if (w && m_blen != 0 && m_periods + 1 == m_blen) finish = 1;
            else if (bus.stop) m_stop_req = 1;
            m_phase = nxt % (2 ** ACC_W);
            if (w) begin
                m_tick = 1;
                m_periods++;
                if (m_pend) begin m_fw = m_shadow; m_pend = 0; end
            end
            if (xfer) begin m_shadow = int'(bus.fw_data); m_pend = 1; end
            if (finish) begin
                m_active = 0; m_phase = 0; m_done = 1;
                if (m_pend) begin m_fw = m_shadow; m_pend = 0; end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [PHASE_W-1:0] c;
        c = PHASE_W'(m_phase >> (ACC_W - PHASE_W));
        return {c, !m_active, (!m_active || !m_pend), m_active, m_tick, m_done};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {bus.counter, bus.lut_reset, bus.fw_ready, bus.busy, bus.period_tick, bus.done};
    endfunction

    task automatic cycle();
        if (reset) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fw(input logic [FW_W-1:0] w);
        bus.fw_valid = 1'b1;
        bus.fw_data  = w;
        cycle();
        bus.fw_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_exp;
        rst_exp = {{PHASE_W{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== rst_exp) begin
            n_fail++; $display("FAIL reset_state got=%h required=%h", obs_vec(), rst_exp);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle got=%h required=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_burst();
        int tick_at[$];
        int done_k, c1;
        done_k = -1; c1 = -1;
        load_fw(16'h0400);
        bus.burst_len = 8'd2; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int k = 0; k < 140; k++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL burst_vec k=%0d got=%h required=%h", k, obs_vec(), exp_vec());
            end
            if (k == 1) c1 = int'(bus.counter);
            if (bus.period_tick) tick_at.push_back(k);
            if (bus.done && done_k < 0) done_k = k;
            cycle();
        end
        n_checks++;
        if (c1 != 16) begin n_fail++; $display("FAIL burst_step got=%0d required=16", c1); end
        n_checks++;
        if (tick_at.size() != 2 || tick_at[0] != 64 || tick_at[1] != 128) begin
            n_fail++; $display("FAIL burst_ticks got n=%0d required ticks at 64,128", tick_at.size());
        end
        n_checks++;
        if (done_k != 128) begin n_fail++; $display("FAIL burst_done got=%0d required=128", done_k); end
        n_checks++;
        if (bus.lut_reset !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL burst_idle got lut_reset=%b busy=%b required 1,0", bus.lut_reset, bus.busy);
        end
    endtask

    task automatic test_stop();
        int stop_k, done_k, done_cnt, maxc;
        stop_k = -1; done_k = -1; done_cnt = -1; maxc = 0;
        load_fw(16'h0400);
        bus.burst_len = '0; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stop_vec k=%0d got=%h required=%h", k, obs_vec(), exp_vec());
            end
            if (bus.busy && int'(bus.counter) > maxc) maxc = int'(bus.counter);
            if (bus.done && done_k < 0) begin done_k = k; done_cnt = int'(bus.counter); end
            bus.stop = 1'b0;
            if (stop_k < 0 && bus.counter == 10'd304) begin bus.stop = 1'b1; stop_k = k; end
            cycle();
        end
        n_checks++;
        if (stop_k != 19) begin n_fail++; $display("FAIL stop_at got=%0d required=19", stop_k); end
        n_checks++;
        if (done_k != 64 || done_cnt != 0) begin
            n_fail++; $display("FAIL stop_done got k=%0d counter=%0d required 64,0", done_k, done_cnt);
        end
        n_checks++;
        if (maxc != 1008) begin n_fail++; $display("FAIL stop_max got=%0d required=1008", maxc); end
    endtask

    task automatic test_load();
        int cnt[100];
        bit rdy[100];
        int off_k, bad, done_k;
        off_k = -1; bad = 0; done_k = -1;
        load_fw(16'h0400);
        bus.burst_len = '0; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL load_vec k=%0d got=%h required=%h", k, obs_vec(), exp_vec());
            end
            cnt[k] = int'(bus.counter);
            rdy[k] = bus.fw_ready;
            bus.fw_valid = 1'b0;
            if (off_k < 0 && bus.counter >= 10'd200) begin
                bus.fw_valid = 1'b1; bus.fw_data = 16'h0800; off_k = k;
            end
            cycle();
        end
        bus.fw_valid = 1'b0;
        n_checks++;
        if (off_k != 13) begin n_fail++; $display("FAIL load_offer got=%0d required=13", off_k); end
        for (int k = 14; k <= 63; k++)
            if (rdy[k] !== 1'b0 || cnt[k] - cnt[k-1] != 16) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL load_hold got %0d bad cycles required 0", bad); end
        n_checks++;
        if (rdy[64] !== 1'b1 || cnt[64] != 0 || cnt[65] != 32 || cnt[66] != 64) begin
            n_fail++; $display("FAIL load_apply got rdy=%b cnt=%0d,%0d,%0d required 1,0,32,64",
                               rdy[64], cnt[64], cnt[65], cnt[66]);
        end
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        for (int k = 0; k < 60; k++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL load_stop_vec k=%0d got=%h required=%h", k, obs_vec(), exp_vec());
            end
            if (bus.done) begin done_k = k; break; end
            cycle();
        end
        n_checks++;
        if (done_k < 0) begin n_fail++; $display("FAIL load_stop_timeout got no done required done within 60"); end
    endtask

    task automatic test_corners();
        bus.start = 1'b1; bus.stop = 1'b1;
        cycle();
        bus.start = 1'b0; bus.stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lut_reset !== 1'b1) begin
                n_fail++; $display("FAIL start_stop_idle got busy=%b done=%b lut_reset=%b required 0,0,1",
                                   bus.busy, bus.done, bus.lut_reset);
            end
            cycle();
        end
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_in_idle got=%h required=%h", obs_vec(), exp_vec());
        end
        load_fw('0);
        bus.burst_len = 8'd1; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL fw0_vec k=%0d got=%h required=%h", k, obs_vec(), exp_vec());
            end
            cycle();
        end
        n_checks++;
        if (bus.busy !== 1'b1 || bus.counter !== '0 || bus.period_tick !== 1'b0) begin
            n_fail++; $display("FAIL fw0_hold got busy=%b counter=%0d required 1,0", bus.busy, bus.counter);
        end
        bus.stop = 1'b1;
        cycle();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL fw0_stopping got busy=%b done=%b required 1,0", bus.busy, bus.done);
        end
        cycle();
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.lut_reset !== 1'b1) begin
            n_fail++; $display("FAIL fw0_done got done=%b busy=%b lut_reset=%b required 1,0,1",
                               bus.done, bus.busy, bus.lut_reset);
        end
    endtask

    task automatic test_async_reset();
        load_fw(16'h0400);
        bus.burst_len = '0; bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL pre_reset_vec got=%h required=%h", obs_vec(), exp_vec());
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.counter !== '0 || bus.lut_reset !== 1'b1 || bus.busy !== 1'b0 ||
            bus.fw_ready !== 1'b1 || bus.done !== 1'b0 || bus.period_tick !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got=%h required counter=0 lut_reset=1 fw_ready=1 others 0", obs_vec());
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_hold got done=%b busy=%b required 0,0", bus.done, bus.busy);
        end
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.stop     = ($urandom_range(0, 39) == 0);
            bus.fw_valid = ($urandom_range(0, 3) == 0);
            bus.fw_data  = ($urandom_range(0, 15) == 0) ? '0 : FW_W'($urandom_range(16'h0200, 16'h4000));
            bus.burst_len = BURST_W'($urandom_range(0, 3));
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_vec i=%0d got=%h required=%h", i, obs_vec(), exp_vec());
            end
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.fw_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.fw_valid = 1'b0;
        bus.fw_data = '0; bus.burst_len = '0;
`ifdef DDS_FREQ_SWEEP_EN
        bus.fw_step = '0; bus.fw_limit = '1;
`endif
        model_reset();
        test_reset();
        test_burst();
        test_stop();
        test_load();
        test_corners();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
